// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, access size.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } lsu_state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      return 4'd1 << sz;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the load/store unit: alignment/legality check,
// little-endian store lane merge and load extract with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rbuf,
   output logic            err,
   output logic [XLEN-1:0] merged,
   output logic [XLEN-1:0] ext
);

   localparam int NB = XLEN / 8;

   logic            misaligned;
   logic            illegal;
   logic [NB-1:0]   lane_en;
   logic [NB-1:0]   byte_en;
   logic [XLEN-1:0] bit_en;
   logic [XLEN-1:0] wsh;
   logic [XLEN-1:0] sh;

   always_comb begin
      misaligned = 1'b0;
      case (funct3[1:0])
         2'd1:    misaligned = off[0];
         2'd2:    misaligned = |off[1:0];
         2'd3:    misaligned = |off;
         default: misaligned = 1'b0;
      endcase
      illegal = we ? funct3[2] : (funct3 == 3'b111);
      err     = misaligned | illegal;
   end

   // A full doubleword enables every lane, so SD falls out of the same merge.
   always_comb begin
      lane_en = NB'((9'd1 << size_bytes(funct3[1:0])) - 9'd1);
      byte_en = lane_en << off;
      bit_en  = '0;
      for (int i = 0; i < NB; i++) begin
         bit_en[8*i +: 8] = {8{byte_en[i]}};
      end
      wsh    = wdata << {off, 3'b000};
      merged = (rbuf & ~bit_en) | (wsh & bit_en);
   end

   always_comb begin
      sh  = rbuf >> {off, 3'b000};
      ext = sh;
      case (funct3)
         F3_B:    ext = {{(XLEN-8){sh[7]}},   sh[7:0]};
         F3_H:    ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
         F3_W:    ext = {{(XLEN-32){sh[31]}}, sh[31:0]};
         F3_BU:   ext = {{(XLEN-8){1'b0}},    sh[7:0]};
         F3_HU:   ext = {{(XLEN-16){1'b0}},   sh[15:0]};
         F3_WU:   ext = {{(XLEN-32){1'b0}},   sh[31:0]};
         default: ext = sh;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the MEM stage and data_memory; sub-word stores
// are read-modify-write, all memory-side and response outputs are registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | req_ready high, waiting for a request
//   S_READ  | mem_read high, doubleword index presented
//   S_WAIT  | mem_read held, read_data captured into rbuf at the edge
//   S_WRITE | mem_write high with the full (merged) doubleword
//   S_RESP  | one-cycle resp_valid pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] endereco,
   output logic [XLEN-1:0]   write_data,
   input  logic [XLEN-1:0]   read_data
);

   lsu_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [2:0]        off_q, off_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rbuf_q, rbuf_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] endereco_q, endereco_d;
   logic [XLEN-1:0]   write_data_q, write_data_d;

   logic              idle;
   logic              cur_we;
   logic [2:0]        cur_f3;
   logic [2:0]        cur_off;
   logic [XLEN-1:0]   cur_wdata;
   logic [XLEN-1:0]   cur_rbuf;
   logic              align_err;
   logic [XLEN-1:0]   merged;
   logic [XLEN-1:0]   ext;

   // In IDLE the datapath looks at the incoming request; afterwards at the latched one.
   // In WAIT it sees read_data directly so the merge/extract result is ready at the capture edge.
   assign idle      = (state_q == S_IDLE);
   assign cur_we    = idle ? req_we           : we_q;
   assign cur_f3    = idle ? req_funct3       : f3_q;
   assign cur_off   = idle ? req_addr[2:0]    : off_q;
   assign cur_wdata = idle ? req_wdata        : wdata_q;
   assign cur_rbuf  = (state_q == S_WAIT) ? read_data : rbuf_q;

   lsu_align #(.XLEN(XLEN)) u_align (
      .we     (cur_we),
      .funct3 (cur_f3),
      .off    (cur_off),
      .wdata  (cur_wdata),
      .rbuf   (cur_rbuf),
      .err    (align_err),
      .merged (merged),
      .ext    (ext)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               off_d   = req_addr[2:0];
               wdata_d = req_wdata;
               if (align_err)                           state_d = S_RESP;
               else if (req_we && req_funct3 == F3_D)   state_d = S_WRITE;
               else                                     state_d = S_READ;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            rbuf_d  = read_data;
            state_d = we_q ? S_WRITE : S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      resp_err_d   = resp_valid_d & align_err;
      resp_rdata_d = (resp_valid_d && !cur_we && !align_err) ? ext : '0;
      mem_read_d   = (state_d == S_READ) || (state_d == S_WAIT);
      mem_write_d  = (state_d == S_WRITE);
      endereco_d   = (idle && req_valid && !align_err) ?
                     {3'b000, req_addr[ADDR_W-1:3]} : endereco_q;
      write_data_d = (state_d == S_WRITE) ? merged : write_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 3'b000;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         endereco_q   <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         endereco_q   <= endereco_d;
         write_data_q <= write_data_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign endereco   = endereco_q;
   assign write_data = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small doubleword memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] endereco;
   logic [63:0] write_data;
   logic [63:0] read_data;

   logic [63:0] mem [0:31];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(64), .XLEN(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .endereco   (endereco),
      .write_data (write_data),
      .read_data  (read_data)
   );

   assign read_data = (endereco < 64'd32) ? mem[endereco[4:0]] : 64'd0;

   always @(posedge clk) begin
      if (mem_write && endereco < 64'd32) mem[endereco[4:0]] <= write_data;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input logic [63:0] exp_rdata, input logic exp_err,
                         input logic [63:0] exp_idx, input logic [63:0] exp_wdata);
      int          lat = 99;
      int          n_rd = 0;
      int          n_wr = 0;
      int          wr_k = 0;
      int          both = 0;
      logic        idx_ok = 1'b1;
      logic        got_err = 1'b0;
      logic [63:0] got_rdata = '0;
      logic [63:0] got_wdata = '0;
      @(negedge clk);
      chk({tag, ".ready"}, 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_read) begin
            n_rd++;
            if (endereco !== exp_idx) idx_ok = 1'b0;
         end
         if (mem_write) begin
            n_wr++;
            wr_k      = k;
            got_wdata = write_data;
            if (endereco !== exp_idx) idx_ok = 1'b0;
         end
         if (mem_read && mem_write) both++;
         if (resp_valid) begin
            lat       = k;
            got_rdata = resp_rdata;
            got_err   = resp_err;
            break;
         end
      end
      chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".n_read"}, 64'(n_rd), 64'(exp_rd));
      chk({tag, ".n_write"}, 64'(n_wr), 64'(exp_wr));
      chk({tag, ".rd_wr_excl"}, 64'(both), 64'd0);
      chk({tag, ".index"}, 64'(idx_ok), 64'd1);
      chk({tag, ".rdata"}, got_rdata, exp_rdata);
      chk({tag, ".err"}, 64'(got_err), 64'(exp_err));
      if (exp_wr > 0) begin
         chk({tag, ".wdata"}, got_wdata, exp_wdata);
         chk({tag, ".wr_cycle"}, 64'(wr_k), 64'(exp_lat - 1));
      end
   endtask

   initial begin
      int          n_resp;
      int          r1k;
      int          r2k;
      logic [63:0] r1;
      logic [63:0] r2;
      logic        dropped;

      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
      mem[0] = 64'd8;

      @(negedge clk);
      @(negedge clk);
      chk("rst.req_ready", 64'(req_ready), 64'd1);
      chk("rst.resp_valid", 64'(resp_valid), 64'd0);
      chk("rst.resp_err", 64'(resp_err), 64'd0);
      chk("rst.resp_rdata", resp_rdata, 64'd0);
      chk("rst.mem_read", 64'(mem_read), 64'd0);
      chk("rst.mem_write", 64'(mem_write), 64'd0);
      chk("rst.endereco", endereco, 64'd0);
      chk("rst.write_data", write_data, 64'd0);
      rst_n = 1'b1;

      //      tag         we    f3    addr     wdata            lat rd wr rdata                   err   idx     wdata
      run_op("ld0",      1'b0, F3_D,  64'h00, 64'd0,            3, 2, 0, 64'd8,                  1'b0, 64'd0,  64'd0);
      run_op("sd50",     1'b1, F3_D,  64'h50, 64'd42,           2, 0, 1, 64'd0,                  1'b0, 64'd10, 64'd42);
      run_op("ld50",     1'b0, F3_D,  64'h50, 64'd0,            3, 2, 0, 64'd42,                 1'b0, 64'd10, 64'd0);
      run_op("sb51",     1'b1, F3_B,  64'h51, 64'hFF,           4, 2, 1, 64'd0,                  1'b0, 64'd10, 64'h0000_0000_0000_FF2A);
      run_op("lb51",     1'b0, F3_B,  64'h51, 64'd0,            3, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd10, 64'd0);
      run_op("lbu51",    1'b0, F3_BU, 64'h51, 64'd0,            3, 2, 0, 64'h0000_0000_0000_00FF, 1'b0, 64'd10, 64'd0);
      run_op("lw52",     1'b0, F3_W,  64'h52, 64'd0,            1, 0, 0, 64'd0,                  1'b1, 64'd0,  64'd0);
      run_op("ld_f3_7",  1'b0, 3'b111, 64'h00, 64'd0,           1, 0, 0, 64'd0,                  1'b1, 64'd0,  64'd0);
      run_op("lh51",     1'b0, F3_H,  64'h51, 64'd0,            1, 0, 0, 64'd0,                  1'b1, 64'd0,  64'd0);
      run_op("sd54",     1'b1, F3_D,  64'h54, 64'd7,            1, 0, 0, 64'd0,                  1'b1, 64'd0,  64'd0);
      run_op("st_f3_4",  1'b1, 3'b100, 64'h50, 64'd7,           1, 0, 0, 64'd0,                  1'b1, 64'd0,  64'd0);
      run_op("sw54",     1'b1, F3_W,  64'h54, 64'h1234_DEAD_BEEF, 4, 2, 1, 64'd0,                1'b0, 64'd10, 64'hDEAD_BEEF_0000_FF2A);
      run_op("sh56",     1'b1, F3_H,  64'h56, 64'h8001,         4, 2, 1, 64'd0,                  1'b0, 64'd10, 64'h8001_BEEF_0000_FF2A);
      run_op("lh56",     1'b0, F3_H,  64'h56, 64'd0,            3, 2, 0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'd10, 64'd0);
      run_op("lhu56",    1'b0, F3_HU, 64'h56, 64'd0,            3, 2, 0, 64'h0000_0000_0000_8001, 1'b0, 64'd10, 64'd0);
      run_op("lw54",     1'b0, F3_W,  64'h54, 64'd0,            3, 2, 0, 64'hFFFF_FFFF_8001_BEEF, 1'b0, 64'd10, 64'd0);
      run_op("lwu54",    1'b0, F3_WU, 64'h54, 64'd0,            3, 2, 0, 64'h0000_0000_8001_BEEF, 1'b0, 64'd10, 64'd0);
      run_op("ld50b",    1'b0, F3_D,  64'h50, 64'd0,            3, 2, 0, 64'h8001_BEEF_0000_FF2A, 1'b0, 64'd10, 64'd0);

      // Reset asserted while the LD 0xA0 is in WAIT.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = F3_D;
      req_addr   = 64'hA0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid.wait_read", 64'(mem_read), 64'd1);
      chk("rst_mid.wait_index", endereco, 64'd20);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid.read_drop", 64'(mem_read), 64'd0);
      chk("rst_mid.ready", 64'(req_ready), 64'd1);
      n_resp = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         if (resp_valid || mem_write) n_resp++;
      end
      chk("rst_mid.no_resp", 64'(n_resp), 64'd0);
      chk("rst_mid.ready_after", 64'(req_ready), 64'd1);
      run_op("ld0_after_rst", 1'b0, F3_D, 64'h00, 64'd0, 3, 2, 0, 64'd8, 1'b0, 64'd0, 64'd0);

      // Back-to-back loads with req_valid held high.
      run_op("sd50_again", 1'b1, F3_D, 64'h50, 64'd42, 2, 0, 1, 64'd0, 1'b0, 64'd10, 64'd42);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = F3_D;
      req_addr   = 64'h00;
      @(posedge clk);
      #1 req_addr = 64'h50;
      n_resp  = 0;
      r1k     = 0;
      r2k     = 0;
      r1      = '0;
      r2      = '0;
      dropped = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            n_resp++;
            if (n_resp == 1) begin
               r1k = k;
               r1  = resp_rdata;
            end else begin
               r2k = k;
               r2  = resp_rdata;
               break;
            end
         end else if (req_ready && !dropped) begin
            dropped = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("b2b.first_cycle", 64'(r1k), 64'd3);
      chk("b2b.first_data", r1, 64'd8);
      chk("b2b.second_cycle", 64'(r2k), 64'd7);
      chk("b2b.second_data", r2, 64'd42);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the MEM pipeline stage and `data_memory`. It accepts one RV64 load or store per handshake and converts the byte address into a doubleword index. Stores narrower than 64 bits are done as a read-modify-write. Load data is extracted and sign- or zero-extended, and a single-cycle response goes back to the pipeline.

## Interface
Parameters:
- `ADDR_W`, 64, width of byte address and `endereco`
- `XLEN`, 64, data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted when `req_valid & req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110; SB 000, SH 001, SW 010, SD 011
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  XLEN  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse, no backpressure
- `resp_rdata`  out  XLEN  extended load data (0 for stores and errors)
- `resp_err`  out  1  misaligned or illegal funct3
- `mem_read`  out  1  to `data_memory`
- `mem_write`  out  1  to `data_memory`
- `endereco`  out  ADDR_W  doubleword index = {3'b0, addr[63:3]}
- `write_data`  out  XLEN  full doubleword to write
- `read_data`  in  XLEN  from `data_memory`

## Operation
- Request fields are latched on acceptance. `off = addr[2:0]`. Size comes from `funct3[1:0]`.
- Misaligned accesses are errors, with no memory access:
  - H: `off[0]` set
  - W: `off[1:0]` nonzero
  - D: `off` nonzero
- Illegal funct3 is also an error with no memory access: load 111, or store with `funct3[2]` = 1.
- States: IDLE, READ, WAIT, WRITE, RESP.
- IDLE: `req_ready` = 1. On accept:
  - error → RESP
  - SD → WRITE
  - load, SB, SH or SW → READ
- READ: `mem_read` = 1, `endereco` driven → WAIT.
- WAIT: `mem_read` = 1, address held. At the edge, `read_data` is captured into `rbuf`.
  - load → RESP
  - store → WRITE
- WRITE: `mem_write` = 1. `write_data` is `req_wdata` for SD; otherwise `rbuf` with lane `[8*off +: 8*size]` replaced by the low bytes of `wdata` (little-endian) → RESP.
- RESP: `resp_valid` = 1 → IDLE.
- Load extract: `sh = rbuf >> 8*off`. B, H and W take bits 7, 15 and 31 as the sign bit; the U variants zero-extend; LD passes through unchanged.
- `mem_read` and `mem_write` are never asserted in the same cycle.

## Timing
- Acceptance edge is T0:
  - load: `resp_valid` high in cycle T0+3
  - SD: T0+2
  - sub-word store: T0+4
  - error: T0+1
- One request in flight. The next acceptance is possible in the cycle after RESP.
- Reset values: state IDLE; `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_read`=0, `mem_write`=0, `endereco`=0, `write_data`=0.
- `mem_*` and `endereco`/`write_data` are registered outputs, glitch-free.
- Reset mid-operation takes effect immediately: `mem_read`/`mem_write` drop asynchronously and the request is discarded with no `resp_valid`. A partial RMW never writes.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `lsu_pkg` holds:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`)
  - state enum `lsu_state_t`
  - `size_bytes()` function
- Sub-module `lsu_align`, combinational: misalignment check, store lane merge, load extract/extend. The FSM stays in `load_store_unit`.

## Test plan
- LD addr 0x0, memory word 0 = 8 → `mem_read` high for 2 cycles with `endereco`=0; `resp_valid` at T0+3, `resp_rdata`=8, `resp_err`=0; `mem_write` stays 0.
- SD addr 0x50, wdata 42 → one `mem_write` cycle with `endereco`=10, `write_data`=42; resp at T0+2. Then LD 0x50 → `resp_rdata`=42.
- SB addr 0x51, wdata 0xFF with word 10 = 42 → `write_data`=0x000000000000FF2A at T0+3. Then LB 0x51 → 0xFFFFFFFFFFFFFFFF; LBU 0x51 → 0xFF.
- LW addr 0x52 → `resp_valid` and `resp_err`=1 at T0+1, `resp_rdata`=0; `mem_read`/`mem_write` never asserted. Load funct3 111 at addr 0 → same result.
- `rst_n` pulsed low during WAIT of LD 0xA0 → `mem_read` drops in the same cycle, no `resp_valid`. After release, `req_ready`=1 and LD 0x0 returns 8 normally.
- `req_valid` held across two LDs (0x0 then 0x50) → second accepted in the cycle after the first RESP; responses 8 then 42, 4 cycles apart.
